// File: rtl/car_turn_ctrl.sv
// Car turn controller: synchronized power/button inputs, per-button debounce,
// and a timed 90-degree turn FSM. Define TURN_CANCEL_EN to let the opposite button abort a turn.
module car_turn_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TURN_CYCLES     = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       power_on,
   input  logic       turn_left,
   input  logic       turn_right,
   output logic       state,
   output logic       clockwise,
   output logic       degree,
   output logic [1:0] heading,
   output logic       turn_done
);

   // state  | meaning
   // IDLE   | waiting for a single debounced button rising edge while powered
   // TURN_L | counter-clockwise turn in progress
   // TURN_R | clockwise turn in progress
   // HOLD   | turn finished or cancelled; waits for both buttons released
   typedef enum logic [1:0] {IDLE, TURN_L, TURN_R, HOLD} fsm_t;

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   fsm_t fsm_q, fsm_d;

   logic [1:0]    pwr_sync_q, pwr_sync_d;
   // Button vectors: bit 0 = left, bit 1 = right.
   logic [1:0]    btn_s1_q, btn_s1_d;
   logic [1:0]    btn_s2_q, btn_s2_d;
   logic [1:0]    btn_deb_q, btn_deb_d;
   logic [1:0]    btn_prev_q, btn_prev_d;
   logic [DW-1:0] db_cnt_q [2];
   logic [DW-1:0] db_cnt_d [2];
   logic [TW-1:0] turn_cnt_q, turn_cnt_d;
   logic [1:0]    heading_q, heading_d;
   logic          turn_done_q, turn_done_d;

   logic          pwr_s;
   logic [1:0]    btn_rise;

   assign pwr_s    = pwr_sync_q[1];
   assign btn_rise = btn_deb_q & ~btn_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         pwr_sync_q  <= '0;
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
         btn_deb_q   <= '0;
         btn_prev_q  <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
         turn_cnt_q  <= '0;
         heading_q   <= '0;
         turn_done_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         pwr_sync_q  <= pwr_sync_d;
         btn_s1_q    <= btn_s1_d;
         btn_s2_q    <= btn_s2_d;
         btn_deb_q   <= btn_deb_d;
         btn_prev_q  <= btn_prev_d;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
         turn_cnt_q  <= turn_cnt_d;
         heading_q   <= heading_d;
         turn_done_q <= turn_done_d;
      end
   end

   // Synchronizers and debouncers; any return to the accepted level restarts the count.
   always_comb begin
      pwr_sync_d = {pwr_sync_q[0], power_on};
      btn_s1_d   = {turn_right, turn_left};
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_deb_q;
      btn_deb_d  = btn_deb_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (btn_s2_q[i] == btn_deb_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            btn_deb_d[i] = btn_s2_q[i];
            db_cnt_d[i]  = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      fsm_d       = fsm_q;
      turn_cnt_d  = '0;
      heading_d   = heading_q;
      turn_done_d = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (pwr_s) begin
               if (btn_rise[0] && !btn_deb_q[1]) begin
                  fsm_d = TURN_L;
               end else if (btn_rise[1] && !btn_deb_q[0]) begin
                  fsm_d = TURN_R;
               end
            end
         end
         TURN_L, TURN_R: begin
            if (!pwr_s) begin
               fsm_d = IDLE;
            end
`ifdef TURN_CANCEL_EN
            else if ((fsm_q == TURN_L && btn_rise[1]) || (fsm_q == TURN_R && btn_rise[0])) begin
               fsm_d = HOLD;
            end
`endif
            else if (turn_cnt_q == TURN_LAST) begin
               fsm_d       = HOLD;
               turn_done_d = 1'b1;
               heading_d   = (fsm_q == TURN_R) ? heading_q + 2'd1 : heading_q - 2'd1;
            end else begin
               turn_cnt_d = turn_cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (btn_deb_q == 2'b00) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      state     = pwr_s;
      degree    = (fsm_q == TURN_L) || (fsm_q == TURN_R);
      clockwise = (fsm_q == TURN_R);
      heading   = heading_q;
      turn_done = turn_done_q;
   end

endmodule

// File: tb/tb_car_turn_ctrl.sv
// Directed bench for car_turn_ctrl with DEBOUNCE_CYCLES=4, TURN_CYCLES=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_car_turn_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       power_on;
   logic       turn_left;
   logic       turn_right;
   logic       state;
   logic       clockwise;
   logic       degree;
   logic [1:0] heading;
   logic       turn_done;

   int checks = 0;
   int passes = 0;

   car_turn_ctrl #(.DEBOUNCE_CYCLES(4), .TURN_CYCLES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .power_on   (power_on),
      .turn_left  (turn_left),
      .turn_right (turn_right),
      .state      (state),
      .clockwise  (clockwise),
      .degree     (degree),
      .heading    (heading),
      .turn_done  (turn_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Press, 2 sync + 4 debounce edges, then FSM edge: degree seen 7 falling edges after the press.
   task automatic do_turn(input bit right, input logic [1:0] exp_head);
      int lat;
      int hi;
      int done_early;
      int cw_bad;
      int rises;
      lat = 0; hi = 0; done_early = 0; cw_bad = 0; rises = 0;
      if (right) turn_right = 1'b1; else turn_left = 1'b1;
      while (degree !== 1'b1 && lat < 20) begin tick(); lat++; end
      checks++;
      if (lat !== 7) $display("FAIL turn_latency: got %0d cycles, expected 7", lat);
      else passes++;
      while (degree === 1'b1 && hi < 20) begin
         if (clockwise !== right) cw_bad++;
         if (turn_done !== 1'b0) done_early++;
         tick(); hi++;
      end
      checks++;
      if (hi !== 8) $display("FAIL degree_width: got %0d cycles, expected 8", hi);
      else passes++;
      checks++;
      if (cw_bad !== 0 || done_early !== 0)
         $display("FAIL turn_flags: clockwise errors %0d, early turn_done %0d, expected 0 and 0", cw_bad, done_early);
      else passes++;
      checks++;
      if (turn_done !== 1'b1 || heading !== exp_head)
         $display("FAIL turn_end: turn_done=%b heading=%0d, expected 1 and %0d", turn_done, heading, exp_head);
      else passes++;
      tick();
      checks++;
      if (turn_done !== 1'b0) $display("FAIL done_pulse_width: turn_done=%b, expected 0", turn_done);
      else passes++;
      repeat (10) begin tick(); if (degree === 1'b1) rises++; end
      checks++;
      if (rises !== 0) $display("FAIL no_repeat: degree high %0d cycles while held, expected 0", rises);
      else passes++;
      turn_left = 1'b0; turn_right = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; power_on = 1'b0; turn_left = 1'b0; turn_right = 1'b0;
      repeat (2) tick();
      power_on = 1'b1;
      repeat (3) tick();
      checks++;
      if ({state, degree, clockwise, heading, turn_done} !== 6'b0)
         $display("FAIL reset_outputs: state=%b degree=%b clockwise=%b heading=%0d turn_done=%b, expected all 0",
                  state, degree, clockwise, heading, turn_done);
      else passes++;
      rst_n = 1'b1;
      tick();
      checks++;
      if (state !== 1'b0) $display("FAIL state_sync1: state=%b, expected 0", state);
      else passes++;
      tick();
      checks++;
      if (state !== 1'b1) $display("FAIL state_sync2: state=%b, expected 1", state);
      else passes++;
      repeat (2) tick();
   endtask

   task automatic test_right_turn();
      do_turn(1'b1, 2'd1);
   endtask

   task automatic test_left_wrap();
      do_turn(1'b0, 2'd0);
      do_turn(1'b0, 2'd3);
      do_turn(1'b1, 2'd0);
      do_turn(1'b1, 2'd1);
      do_turn(1'b1, 2'd2);
      do_turn(1'b1, 2'd3);
      do_turn(1'b1, 2'd0);
   endtask

   task automatic test_bounce();
      int rises;
      rises = 0;
      for (int i = 0; i < 12; i++) begin
         turn_right = (i % 4) < 2;
         tick();
         if (degree === 1'b1) rises++;
      end
      turn_right = 1'b0;
      repeat (15) begin tick(); if (degree === 1'b1) rises++; end
      checks++;
      if (rises !== 0) $display("FAIL bounce_reject: degree high %0d cycles, expected 0", rises);
      else passes++;
   endtask

   task automatic test_both();
      int rises;
      rises = 0;
      turn_left = 1'b1; turn_right = 1'b1;
      repeat (20) begin tick(); if (degree === 1'b1) rises++; end
      checks++;
      if (rises !== 0) $display("FAIL both_pressed: degree high %0d cycles, expected 0", rises);
      else passes++;
      turn_left = 1'b0; turn_right = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_power_drop();
      int lat;
      int dones;
      int rises;
      logic [1:0] h0;
      lat = 0; dones = 0; rises = 0;
      h0 = heading;
      turn_right = 1'b1;
      while (degree !== 1'b1 && lat < 20) begin tick(); lat++; end
      repeat (3) tick();
      power_on = 1'b0;
      tick(); tick();
      checks++;
      if (state !== 1'b0) $display("FAIL power_state: state=%b, expected 0", state);
      else passes++;
      tick();
      checks++;
      if (degree !== 1'b0 || clockwise !== 1'b0)
         $display("FAIL power_abort: degree=%b clockwise=%b, expected 0 and 0", degree, clockwise);
      else passes++;
      repeat (12) begin if (turn_done === 1'b1) dones++; tick(); end
      checks++;
      if (dones !== 0 || heading !== h0)
         $display("FAIL power_no_done: turn_done pulses %0d heading=%0d, expected 0 and %0d", dones, heading, h0);
      else passes++;
      turn_right = 1'b0;
      repeat (10) tick();
      turn_left = 1'b1;
      repeat (15) begin tick(); if (degree === 1'b1) rises++; end
      checks++;
      if (rises !== 0) $display("FAIL unpowered_press: degree high %0d cycles, expected 0", rises);
      else passes++;
      turn_left = 1'b0;
      power_on = 1'b1;
      repeat (12) tick();
   endtask

   task automatic test_cancel();
      int lat;
      int hi;
      int dones;
      logic [1:0] h0;
      lat = 0; hi = 0; dones = 0;
      h0 = heading;
      turn_right = 1'b1;
      tick();
      turn_left = 1'b1;
      while (degree !== 1'b1 && lat < 20) begin tick(); lat++; end
      while (degree === 1'b1 && hi < 20) begin
         if (turn_done === 1'b1) dones++;
         tick(); hi++;
      end
      repeat (3) begin if (turn_done === 1'b1) dones++; tick(); end
`ifdef TURN_CANCEL_EN
      checks++;
      if (hi !== 1) $display("FAIL cancel_width: degree high %0d cycles, expected 1", hi);
      else passes++;
      checks++;
      if (dones !== 0 || heading !== h0)
         $display("FAIL cancel_result: turn_done pulses %0d heading=%0d, expected 0 and %0d", dones, heading, h0);
      else passes++;
`else
      checks++;
      if (hi !== 8) $display("FAIL opposite_ignored: degree high %0d cycles, expected 8", hi);
      else passes++;
      checks++;
      if (dones !== 1 || heading !== h0 + 2'd1)
         $display("FAIL opposite_result: turn_done pulses %0d heading=%0d, expected 1 and %0d",
                  dones, heading, 2'(h0 + 2'd1));
      else passes++;
`endif
      turn_left = 1'b0; turn_right = 1'b0;
      repeat (10) tick();
   endtask

   initial begin
      test_reset();
      test_right_turn();
      test_left_wrap();
      test_bounce();
      test_both();
      test_power_drop();
      test_cancel();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
